fp_div_ctrl: RTL

Handshake controller that sits directly upstream of the combinational floating-point divider (FP_Div). Accepts one operand pair per transaction, detects IEEE special operands and resolves them locally, otherwise drives the divider and samples its output after a fixed multicycle settle window. Returns a registered, NaN-boxed result with exception flags over a valid/ready interface.

---
 rtl/fp_div_ctrl_if.sv | 35 +++
 rtl/fp_div_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/fp_div_ctrl_if.sv
// Operand/result bundle between upstream, fp_div_ctrl and the combinational divider.
// The controller takes the slave modport; the producer/consumer side takes master.
interface fp_div_ctrl_if #(
  parameter int DATA_WIDTH = 64
);
  // Handshake rules. A transfer happens on a rising edge where valid && ready.
  // in_valid/out_ready carry operands in. out_valid/in_ready carry the result out.
  // A source keeps its payload stable while valid is high and ready is low.
  // A sink may raise ready without waiting for valid.
  logic                  in_valid;
  logic                  out_ready;
  logic                  in_fmt;
  logic [DATA_WIDTH-1:0] in_numA;
  logic [DATA_WIDTH-1:0] in_numB;
  logic [DATA_WIDTH-1:0] out_div_numA;
  logic [DATA_WIDTH-1:0] out_div_numB;
  logic                  out_div_fmt;
  logic [DATA_WIDTH-1:0] in_div_result;
  logic                  out_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] out_result;
  logic [2:0]            out_flags;

  modport slave (
    input  in_valid, in_fmt, in_numA, in_numB, in_div_result, in_ready,
    output out_ready, out_div_numA, out_div_numB, out_div_fmt,
    output out_valid, out_result, out_flags
  );

  modport master (
    output in_valid, in_fmt, in_numA, in_numB, in_div_result, in_ready,
    input  out_ready, out_div_numA, out_div_numB, out_div_fmt,
    input  out_valid, out_result, out_flags
  );
endinterface

// File: rtl/fp_div_ctrl.sv
// Valid/ready wrapper around a combinational FP divider that samples the result after a settle window.
// Define FP_DIV_CTRL_SPECIAL_EN to resolve NaN/inf/zero operands locally without waiting on the divider.
module fp_div_ctrl #(
  parameter int DATA_WIDTH    = 64,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic         in_clk,
  input  logic         in_rst_n,
  fp_div_ctrl_if.slave bus,
  output logic [1:0]   dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] numa_q, numa_d;
  logic [DATA_WIDTH-1:0] numb_q, numb_d;
  logic                  fmt_q, fmt_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic [2:0]            flags_q, flags_d;

  logic                  div_sign;
  logic [DATA_WIDTH-1:0] div_fixed;
  logic                  unused_div_msb;

  // The divider's own sign is ignored; the quotient sign is always sA ^ sB.
  assign div_sign  = fmt_q ? (numa_q[63] ^ numb_q[63]) : (numa_q[31] ^ numb_q[31]);
  assign div_fixed = fmt_q ? {div_sign, bus.in_div_result[62:0]}
                           : {32'hFFFF_FFFF, div_sign, bus.in_div_result[30:0]};
  assign unused_div_msb = bus.in_div_result[63];

`ifdef FP_DIV_CTRL_SPECIAL_EN
  typedef struct packed {
    logic sign;
    logic is_nan;
    logic is_inf;
    logic is_zero;
  } opclass_t;

  // Subnormals report as zero, so they follow the zero rules below.
  function automatic opclass_t classify(input logic [DATA_WIDTH-1:0] x, input logic dbl);
    opclass_t c;
    if (dbl) begin
      c.sign    = x[63];
      c.is_nan  = (&x[62:52]) && (|x[51:0]);
      c.is_inf  = (&x[62:52]) && !(|x[51:0]);
      c.is_zero = !(|x[62:52]);
    end else begin
      c.sign    = x[31];
      c.is_nan  = (&x[30:23]) && (|x[22:0]);
      c.is_inf  = (&x[30:23]) && !(|x[22:0]);
      c.is_zero = !(|x[30:23]);
    end
    return c;
  endfunction

  opclass_t              cls_a, cls_b;
  logic                  spec_sign;
  logic                  spec_hit;
  logic [DATA_WIDTH-1:0] spec_result;
  logic [2:0]            spec_flags;
  logic [DATA_WIDTH-1:0] inf_val, zero_val, qnan_val;

  always_comb begin
    cls_a       = classify(bus.in_numA, bus.in_fmt);
    cls_b       = classify(bus.in_numB, bus.in_fmt);
    spec_sign   = cls_a.sign ^ cls_b.sign;
    inf_val     = bus.in_fmt ? {spec_sign, 11'h7FF, 52'h0}
                             : {32'hFFFF_FFFF, spec_sign, 8'hFF, 23'h0};
    zero_val    = bus.in_fmt ? {spec_sign, 63'h0}
                             : {32'hFFFF_FFFF, spec_sign, 31'h0};
    qnan_val    = bus.in_fmt ? 64'h7FF8_0000_0000_0000 : 64'hFFFF_FFFF_7FC0_0000;
    spec_hit    = 1'b0;
    spec_result = '0;
    spec_flags  = 3'b000;
    // Once the invalid cases are gone the remaining conditions are disjoint.
    if (cls_a.is_nan || cls_b.is_nan || (cls_a.is_zero && cls_b.is_zero) ||
        (cls_a.is_inf && cls_b.is_inf)) begin
      spec_hit    = 1'b1;
      spec_result = qnan_val;
      spec_flags  = 3'b101;
    end else if (cls_b.is_zero && !cls_a.is_inf) begin
      spec_hit    = 1'b1;
      spec_result = inf_val;
      spec_flags  = 3'b011;
    end else if (cls_a.is_inf) begin
      spec_hit    = 1'b1;
      spec_result = inf_val;
      spec_flags  = 3'b001;
    end else if (cls_a.is_zero || cls_b.is_inf) begin
      spec_hit    = 1'b1;
      spec_result = zero_val;
      spec_flags  = 3'b001;
    end
  end
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    numa_d   = numa_q;
    numb_d   = numb_q;
    fmt_d    = fmt_q;
    result_d = result_q;
    flags_d  = flags_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          numa_d = bus.in_numA;
          numb_d = bus.in_numB;
          fmt_d  = bus.in_fmt;
`ifdef FP_DIV_CTRL_SPECIAL_EN
          if (spec_hit) begin
            result_d = spec_result;
            flags_d  = spec_flags;
            state_d  = DONE;
          end else begin
            cnt_d   = CNT_LOAD;
            state_d = BUSY;
          end
`else
          cnt_d   = CNT_LOAD;
          state_d = BUSY;
`endif
        end
      end
      BUSY: begin
        // The divider output is only trusted once the settle window has elapsed.
        if (cnt_q == 4'd0) begin
          result_d = div_fixed;
          flags_d  = 3'b000;
          state_d  = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        if (bus.in_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      numa_q   <= '0;
      numb_q   <= '0;
      fmt_q    <= 1'b0;
      result_q <= '0;
      flags_q  <= 3'b000;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      numa_q   <= numa_d;
      numb_q   <= numb_d;
      fmt_q    <= fmt_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  assign bus.out_ready    = (state_q == IDLE);
  assign bus.out_valid    = (state_q == DONE);
  assign bus.out_div_numA = numa_q;
  assign bus.out_div_numB = numb_q;
  assign bus.out_div_fmt  = fmt_q;
  assign bus.out_result   = result_q;
  assign bus.out_flags    = flags_q;
  assign dbg_state_o      = state_q;

endmodule
